// File: rtl/iob_axi_arbiter_pkg.sv
// Shared types and helpers for the IOb round-robin arbiter.
package iob_axi_arbiter_pkg;

  // Arbiter state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    RDATA = 2'd2
  } arb_state_t;

  // Widest strobe the write-detect helper accepts (DATA_W up to 256).
  localparam int STRB_MAX = 32;

  // An IOb transfer is a write when any strobe bit is set.
  function automatic logic iob_is_write(input logic [STRB_MAX-1:0] wstrb);
    return |wstrb;
  endfunction

endpackage

// File: rtl/iob_reg_re.sv
// Register with synchronous reset, clock enable and load enable.
module iob_reg_re #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  // Reset dominates; otherwise load only when both enables are high.
  always_ff @(posedge clk_i) begin
    if (rst_i)              data_o <= RST_VAL;
    else if (cke_i && en_i) data_o <= data_i;
  end

endmodule

// File: rtl/iob_rr_prio_enc.sv
// Round-robin priority encoder: first set request at or above ptr, wrapping.
module iob_rr_prio_enc #(
  parameter  int N_REQ = 2,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [PTR_W-1:0]   off;
  logic [PTR_W:0]     sum;

  // Rotate so ptr lands at bit 0.
  assign dbl = {req_i, req_i};
  assign rot = dbl[int'(ptr_i) +: N_REQ];

  // Find-first in rotated space, then map the offset back to an absolute index.
  always_comb begin
    off     = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!valid_o && rot[i]) begin
        valid_o = 1'b1;
        off     = PTR_W'(i);
      end
    end
    sum     = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
    idx_o   = sum[PTR_W-1:0];
    grant_o = '0;
    grant_o[idx_o] = valid_o;
  end

endmodule

// File: rtl/iob_axi_arbiter.sv
// Round-robin arbiter sharing one IOb master port among N_REQ requesters,
// one outstanding transaction, with a read-response watchdog.
module iob_axi_arbiter
  import iob_axi_arbiter_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                       clk_i,
  input  logic                       cke_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_avalid_i,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata_i,
  input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb_i,
  output logic [DATA_W-1:0]          req_rdata_o,
  output logic [N_REQ-1:0]           req_rvalid_o,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic                       m_avalid_o,
  output logic [ADDR_W-1:0]          m_addr_o,
  output logic [DATA_W-1:0]          m_wdata_o,
  output logic [DATA_W/8-1:0]        m_wstrb_o,
  input  logic [DATA_W-1:0]          m_rdata_i,
  input  logic                       m_rvalid_i,
  input  logic                       m_ready_i,
  output logic [N_REQ-1:0]           grant_o,
  output logic                       err_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(N_REQ);

  arb_state_t           state_q, state_d;
  logic [1:0]           state_bits_q;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]     gidx_q, gidx_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 err_q, err_d;

  logic [N_REQ-1:0]     enc_grant;
  logic [PTR_W-1:0]     enc_idx;
  logic                 enc_valid;

  logic                 cur_av;
  logic [ADDR_W-1:0]    cur_addr;
  logic [DATA_W-1:0]    cur_wdata;
  logic [STRB_W-1:0]    cur_wstrb;
  logic [PTR_W:0]       g_plus;
  logic [PTR_W-1:0]     ptr_adv;
  logic                 done;

  iob_reg_re #(.DATA_W(2), .RST_VAL(2'd0)) state_reg (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .en_i(1'b1),
    .data_i(state_d), .data_o(state_bits_q)
  );
  assign state_q = arb_state_t'(state_bits_q);

  iob_reg_re #(.DATA_W(N_REQ)) grant_reg (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .en_i(1'b1),
    .data_i(grant_d), .data_o(grant_q)
  );

  iob_reg_re #(.DATA_W(PTR_W)) gidx_reg (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .en_i(1'b1),
    .data_i(gidx_d), .data_o(gidx_q)
  );

  iob_reg_re #(.DATA_W(PTR_W)) rr_ptr_reg (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .en_i(1'b1),
    .data_i(rr_ptr_d), .data_o(rr_ptr_q)
  );

  iob_reg_re #(.DATA_W(TIMEOUT_W)) wdog_reg (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .en_i(1'b1),
    .data_i(wdog_d), .data_o(wdog_q)
  );

  iob_reg_re #(.DATA_W(1)) err_reg (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .en_i(1'b1),
    .data_i(err_d), .data_o(err_q)
  );

  iob_rr_prio_enc #(.N_REQ(N_REQ)) prio_enc (
    .req_i(req_avalid_i), .ptr_i(rr_ptr_q),
    .grant_o(enc_grant), .idx_o(enc_idx), .valid_o(enc_valid)
  );

  // Granted requester's slices.
  assign cur_av    = req_avalid_i[gidx_q];
  assign cur_addr  = req_addr_i[int'(gidx_q)*ADDR_W +: ADDR_W];
  assign cur_wdata = req_wdata_i[int'(gidx_q)*DATA_W +: DATA_W];
  assign cur_wstrb = req_wstrb_i[int'(gidx_q)*STRB_W +: STRB_W];

  // Pointer after the current grant, wrapping at N_REQ.
  assign g_plus  = {1'b0, gidx_q} + (PTR_W+1)'(1);
  assign ptr_adv = (g_plus == (PTR_W+1)'(N_REQ)) ? '0 : g_plus[PTR_W-1:0];

  assign grant_o = grant_q;
  assign err_o   = err_q;

  // Next-state and output decode; 'done' ends the transaction and rotates priority.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_ptr_d     = rr_ptr_q;
    wdog_d       = wdog_q;
    err_d        = err_q;
    done         = 1'b0;
    m_avalid_o   = 1'b0;
    m_addr_o     = '0;
    m_wdata_o    = '0;
    m_wstrb_o    = '0;
    req_ready_o  = '0;
    req_rvalid_o = '0;
    req_rdata_o  = '0;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d = ADDR;
          grant_d = enc_grant;
          gidx_d  = enc_idx;
        end
      end
      ADDR: begin
        m_avalid_o          = cur_av;
        m_addr_o            = cur_addr;
        m_wdata_o           = cur_wdata;
        m_wstrb_o           = cur_wstrb;
        req_ready_o[gidx_q] = m_ready_i;
        if (!cur_av) begin
          done = 1'b1;
        end else if (m_ready_i) begin
          if (iob_is_write(STRB_MAX'(cur_wstrb))) begin
            done = 1'b1;
          end else begin
            state_d = RDATA;
            wdog_d  = '0;
          end
        end
      end
      RDATA: begin
        req_rvalid_o[gidx_q] = m_rvalid_i;
        req_rdata_o          = m_rdata_i;
        if (m_rvalid_i) begin
          done = 1'b1;
        end else if (&wdog_q) begin
          // Watchdog expiry: fake an empty response so the requester unblocks.
          req_rvalid_o[gidx_q] = 1'b1;
          req_rdata_o          = '0;
          err_d                = 1'b1;
          done                 = 1'b1;
        end else begin
          wdog_d = wdog_q + TIMEOUT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d  = IDLE;
      grant_d  = '0;
      rr_ptr_d = ptr_adv;
    end
  end

endmodule

// File: tb/tb_iob_axi_arbiter.sv
// Directed table-driven bench for iob_axi_arbiter (N_REQ=2, TIMEOUT_W=4).
module tb_iob_axi_arbiter;

  logic        clk = 1'b0;
  logic        cke, rst;
  logic [1:0]  av, wr;
  logic        rdy, rv;
  logic [31:0] rd;

  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [31:0] req_rdata, m_addr, m_wdata;
  logic [1:0]  req_rvalid, req_ready, grant;
  logic        m_avalid, err;
  logic [3:0]  m_wstrb;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign req_addr  = {32'h0000_0200, 32'h0000_0100};
  assign req_wdata = {32'h5A5A_5A5A, 32'hA5A5_A5A5};
  assign req_wstrb = {wr[1] ? 4'hF : 4'h0, wr[0] ? 4'hF : 4'h0};

  iob_axi_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_W(4)) dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst),
    .req_avalid_i(av), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb), .req_rdata_o(req_rdata), .req_rvalid_o(req_rvalid),
    .req_ready_o(req_ready), .m_avalid_o(m_avalid), .m_addr_o(m_addr),
    .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_rdata_i(rd), .m_rvalid_i(rv),
    .m_ready_i(rdy), .grant_o(grant), .err_o(err)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  av, wr;
    logic        rdy, rv;
    logic [31:0] rd;
    logic [1:0]  e_gnt;
    logic        e_mav;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_rdy, e_rv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vec [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passes++;
  endtask

  // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
  task automatic step(input logic r, input logic [1:0] a, input logic [1:0] w,
                      input logic rdy_v, input logic rv_v, input logic [31:0] rd_v);
    @(negedge clk);
    rst = r; av = a; wr = w; rdy = rdy_v; rv = rv_v; rd = rd_v;
    #1;
  endtask

  initial begin
    cke = 1'b1; rst = 1'b1; av = '0; wr = '0; rdy = 1'b0; rv = 1'b0; rd = '0;

    //          rst av     wr     rdy   rv    rd      gnt    mav   addr     wdata         rdy_o  rv_o   rdata
    vec[0]  = '{0, 2'b01, 2'b01, 1'b1, 1'b0, 32'h0,  2'b00, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0};
    vec[1]  = '{0, 2'b01, 2'b01, 1'b1, 1'b0, 32'h0,  2'b01, 1'b1, 32'h100, 32'hA5A5A5A5, 2'b01, 2'b00, 32'h0};
    vec[2]  = '{0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0};
    vec[3]  = '{1, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0};
    vec[4]  = '{0, 2'b11, 2'b00, 1'b1, 1'b1, 32'h77, 2'b00, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0};
    vec[5]  = '{0, 2'b11, 2'b00, 1'b1, 1'b0, 32'h0,  2'b01, 1'b1, 32'h100, 32'hA5A5A5A5, 2'b01, 2'b00, 32'h0};
    vec[6]  = '{0, 2'b10, 2'b00, 1'b1, 1'b1, 32'h11, 2'b01, 1'b0, 32'h0,   32'h0,        2'b00, 2'b01, 32'h11};
    vec[7]  = '{0, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0};
    vec[8]  = '{0, 2'b10, 2'b00, 1'b1, 1'b0, 32'h0,  2'b10, 1'b1, 32'h200, 32'h5A5A5A5A, 2'b10, 2'b00, 32'h0};
    vec[9]  = '{0, 2'b00, 2'b00, 1'b0, 1'b1, 32'h22, 2'b10, 1'b0, 32'h0,   32'h0,        2'b00, 2'b10, 32'h22};
    vec[10] = '{0, 2'b01, 2'b01, 1'b0, 1'b0, 32'h0,  2'b00, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0};
    vec[11] = '{0, 2'b01, 2'b01, 1'b0, 1'b0, 32'h0,  2'b01, 1'b1, 32'h100, 32'hA5A5A5A5, 2'b00, 2'b00, 32'h0};
    vec[12] = '{0, 2'b00, 2'b01, 1'b0, 1'b0, 32'h0,  2'b01, 1'b0, 32'h100, 32'hA5A5A5A5, 2'b00, 2'b00, 32'h0};
    vec[13] = '{0, 2'b00, 2'b00, 1'b0, 1'b1, 32'h55, 2'b00, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0};

    // Reset and check reset state.
    step(1, 2'b00, 2'b00, 0, 0, 32'h0);
    step(1, 2'b00, 2'b00, 0, 0, 32'h0);
    chk("reset grant", 32'(grant), 32'h0);
    chk("reset m_avalid", 32'(m_avalid), 32'h0);
    chk("reset ready", 32'(req_ready), 32'h0);
    chk("reset rvalid", 32'(req_rvalid), 32'h0);
    chk("reset rdata", req_rdata, 32'h0);
    chk("reset err", 32'(err), 32'h0);

    // Table: single write, two simultaneous reads, protocol drop, late rvalid.
    for (int i = 0; i < 14; i++) begin
      step(vec[i].rst, vec[i].av, vec[i].wr, vec[i].rdy, vec[i].rv, vec[i].rd);
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(vec[i].e_gnt));
      chk($sformatf("v%0d m_avalid", i), 32'(m_avalid), 32'(vec[i].e_mav));
      chk($sformatf("v%0d m_addr", i), m_addr, vec[i].e_addr);
      chk($sformatf("v%0d m_wdata", i), m_wdata, vec[i].e_wdata);
      chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(vec[i].e_rdy));
      chk($sformatf("v%0d rvalid", i), 32'(req_rvalid), 32'(vec[i].e_rv));
      chk($sformatf("v%0d rdata", i), req_rdata, vec[i].e_rdata);
      chk($sformatf("v%0d err", i), 32'(err), 32'h0);
    end

    // Fairness: both requesters writing continuously, grants alternate.
    step(1, 2'b00, 2'b00, 0, 0, 32'h0);
    for (int k = 0; k < 12; k++) begin
      step(0, 2'b11, 2'b11, 1, 0, 32'h0);
      if (k % 2 == 0) begin
        chk($sformatf("rr%0d idle grant", k), 32'(grant), 32'h0);
      end else begin
        chk($sformatf("rr%0d grant", k), 32'(grant), ((k / 2) % 2 == 0) ? 32'h1 : 32'h2);
        chk($sformatf("rr%0d ready", k), 32'(req_ready), ((k / 2) % 2 == 0) ? 32'h1 : 32'h2);
      end
    end

    // Watchdog: read with no response times out after 15 waiting cycles.
    step(1, 2'b00, 2'b00, 0, 0, 32'h0);
    step(0, 2'b01, 2'b00, 1, 0, 32'h0);
    step(0, 2'b01, 2'b00, 1, 0, 32'h0);
    chk("wd accept grant", 32'(grant), 32'h1);
    for (int k = 0; k < 15; k++) begin
      step(0, 2'b00, 2'b00, 0, 0, 32'hDEAD_BEEF);
      chk($sformatf("wd wait%0d rvalid", k), 32'(req_rvalid), 32'h0);
    end
    step(0, 2'b00, 2'b00, 0, 0, 32'hDEAD_BEEF);
    chk("wd expire rvalid", 32'(req_rvalid), 32'h1);
    chk("wd expire rdata", req_rdata, 32'h0);
    chk("wd expire err pre", 32'(err), 32'h0);
    step(0, 2'b00, 2'b00, 0, 1, 32'h44);
    chk("wd late rvalid", 32'(req_rvalid), 32'h0);
    chk("wd late rdata", req_rdata, 32'h0);
    chk("wd err set", 32'(err), 32'h1);
    chk("wd idle grant", 32'(grant), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(0, 2'b00, 2'b00, 0, 0, 32'h0);
      chk($sformatf("wd err sticky%0d", k), 32'(err), 32'h1);
    end
    step(1, 2'b00, 2'b00, 0, 0, 32'h0);
    step(0, 2'b00, 2'b00, 0, 0, 32'h0);
    chk("wd err cleared", 32'(err), 32'h0);

    // Reset in RDATA: stale rvalid discarded, pointer back at 0.
    step(0, 2'b01, 2'b01, 1, 0, 32'h0);
    step(0, 2'b01, 2'b01, 1, 0, 32'h0);
    step(0, 2'b01, 2'b00, 1, 0, 32'h0);
    step(0, 2'b01, 2'b00, 1, 0, 32'h0);
    chk("rst pre grant", 32'(grant), 32'h1);
    step(1, 2'b00, 2'b00, 0, 0, 32'h0);
    step(0, 2'b00, 2'b00, 0, 1, 32'h33);
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst m_avalid", 32'(m_avalid), 32'h0);
    chk("rst stale rvalid", 32'(req_rvalid), 32'h0);
    chk("rst stale rdata", req_rdata, 32'h0);
    step(0, 2'b11, 2'b00, 1, 0, 32'h0);
    step(0, 2'b11, 2'b00, 0, 0, 32'h0);
    chk("rst rearb grant", 32'(grant), 32'h1);

    // Clock enable low in ADDR freezes the transaction.
    step(1, 2'b00, 2'b00, 0, 0, 32'h0);
    step(0, 2'b01, 2'b01, 0, 0, 32'h0);
    step(0, 2'b01, 2'b01, 0, 0, 32'h0);
    chk("cke addr grant", 32'(grant), 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cke = 1'b0; rdy = (k >= 3);
      #1;
      chk($sformatf("cke hold%0d grant", k), 32'(grant), 32'h1);
      chk($sformatf("cke hold%0d m_avalid", k), 32'(m_avalid), 32'h1);
    end
    @(negedge clk);
    cke = 1'b1; rdy = 1'b1;
    #1;
    chk("cke resume grant", 32'(grant), 32'h1);
    chk("cke resume ready", 32'(req_ready), 32'h1);
    step(0, 2'b00, 2'b00, 0, 0, 32'h0);
    chk("cke done grant", 32'(grant), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
